sign_actuation: RTL and testbench
=================================

SIGN_ACTUATION -- requirements
Module: sign_actuation

Interface
REQ-001 Parameter STEP_CYCLES, default 4: clock cycles between successive finger updates; legal range 1..65535.
REQ-002 Parameter HOLD_CYCLES, default 8: clock cycles the final pattern is held before completion; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 sign_in  input  4  sign code to be reproduced.
REQ-006 sign_valid  input  1  sign_in is valid this cycle.
REQ-007 sign_ready  output  1  block can accept a sign this cycle.
REQ-008 abort  input  1  cancel the sequence in progress.
REQ-009 thumb_cmd, index_cmd, middle_cmd, ring_cmd, pinky_cmd  output  1 each  finger actuator command; 1 = extended, 0 = curled.
REQ-010 busy  output  1  sequence in progress.
REQ-011 done  output  1  one-cycle pulse: sequence completed.
REQ-012 err  output  1  one-cycle pulse: unsupported code accepted.

Function
REQ-013 Pattern order {thumb,index,middle,ring,pinky}; code table SHALL be: 0=00000, 1=01000, 2=01100, 3=01110, 4=01111, 5=11111, 6=10001, 7=11000, 8=11100, 9=01001, 10=10000; codes 11-15 unsupported.
REQ-014 FSM states SHALL be IDLE, STEP, HOLD; busy = (state != IDLE); sign_ready = (state == IDLE).
REQ-015 Handshake: a sign is accepted on a rising edge where sign_valid & sign_ready are both 1; sign_valid while busy is ignored, not queued.
REQ-016 Supported code accepted at edge A: target pattern latched, state -> STEP, thumb_cmd updated to target thumb bit at edge A.
REQ-017 Finger k (0=thumb..4=pinky) SHALL be updated at edge A + k*STEP_CYCLES; other fingers keep their prior values until their own update.
REQ-018 State SHALL enter HOLD at edge A + 5*STEP_CYCLES, and return to IDLE with done=1 at edge A + 5*STEP_CYCLES + HOLD_CYCLES.
REQ-019 done SHALL be high for exactly one cycle; sign_ready is high in that same cycle, so a new sign may be accepted back-to-back.
REQ-020 Unsupported code accepted: err=1 for exactly one cycle after the accept edge, state stays IDLE, finger commands unchanged, no done.
REQ-021 Finger commands SHALL retain the completed pattern after done until the next update, abort, or reset.
REQ-022 abort=1 on an edge in STEP or HOLD: all five commands -> 0, state -> IDLE, no done pulse.
REQ-023 abort and completion on the same edge: abort wins; done stays 0.
REQ-024 abort in IDLE SHALL have no effect; abort together with an accepting handshake in IDLE: the sign is accepted normally.
REQ-025 Step/hold counters SHALL be 16 bits, counting from 0 to parameter-1, and SHALL never wrap past the terminal value.

Reset
REQ-026 rst=1 on an edge, in any state: state -> IDLE, all finger commands=0, busy=0, done=0, err=0, counters=0, latched target=0.
REQ-027 rst overrides abort, sign_valid and completion on the same edge; sign_ready=1 in the first cycle after rst is released.

Verification (STEP_CYCLES=2, HOLD_CYCLES=3)
REQ-028 Reset, then accept code 5 at edge A -> thumb=1 at A, index at A+2, middle at A+4, ring at A+6, pinky at A+8; done pulse at A+13; pattern 11111 held afterwards.
REQ-029 After code 5 completes, accept code 9 -> thumb falls to 0 at A, index stays 1, middle 0 at A+4, ring 0 at A+6, pinky stays 1; final pattern 01001.
REQ-030 Accept code 12 -> err=1 for one cycle, sign_ready stays 1, commands unchanged, busy stays 0.
REQ-031 Accept code 4; assert abort at A+5 -> all commands 0 at A+5, busy=0, no done; code 3 accepted on the next edge runs normally.
REQ-032 Hold sign_valid=1 with changing sign_in while busy -> ignored; code presented in the done cycle is accepted at that edge.
REQ-033 Assert rst at A+3 during code 7, with abort=1 on the same edge -> all outputs 0 after that edge, sign_ready=1 after rst is released.

Source files
------------

// File: rtl/sign_actuation.sv
// Sign-language hand actuator sequencer: decodes a sign code into a five-finger
// pattern and drives the fingers one at a time, thumb first, then holds the final pose.
module sign_actuation #(
  parameter int STEP_CYCLES = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sign_in,
  input  logic       sign_valid,
  output logic       sign_ready,
  input  logic       abort,
  output logic       thumb_cmd,
  output logic       index_cmd,
  output logic       middle_cmd,
  output logic       ring_cmd,
  output logic       pinky_cmd,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [15:0] STEP_LAST = 16'(STEP_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  // Bit 5 flags a supported code; bits 4:0 are {thumb,index,middle,ring,pinky}.
  function automatic logic [5:0] decode_sign(input logic [3:0] code);
    case (code)
      4'd0:    decode_sign = {1'b1, 5'b00000};
      4'd1:    decode_sign = {1'b1, 5'b01000};
      4'd2:    decode_sign = {1'b1, 5'b01100};
      4'd3:    decode_sign = {1'b1, 5'b01110};
      4'd4:    decode_sign = {1'b1, 5'b01111};
      4'd5:    decode_sign = {1'b1, 5'b11111};
      4'd6:    decode_sign = {1'b1, 5'b10001};
      4'd7:    decode_sign = {1'b1, 5'b11000};
      4'd8:    decode_sign = {1'b1, 5'b11100};
      4'd9:    decode_sign = {1'b1, 5'b01001};
      4'd10:   decode_sign = {1'b1, 5'b10000};
      default: decode_sign = {1'b0, 5'b00000};
    endcase
  endfunction

  state_t      state_r, state_nxt_s;
  logic [15:0] cnt_r, cnt_nxt_s;
  logic [2:0]  finger_r, finger_nxt_s;
  logic [2:0]  finger_idx_s;
  logic [4:0]  cmd_r, cmd_nxt_s;
  logic [4:0]  target_r, target_nxt_s;
  logic        done_r, done_nxt_s;
  logic        err_r, err_nxt_s;
  logic [5:0]  lut_s;

  // finger_r counts 0=thumb..4=pinky; the pattern vector holds the thumb in bit 4.
  assign finger_idx_s = 3'd4 - finger_r;
  assign lut_s        = decode_sign(sign_in);

  // Next-state, counter and actuator-pattern logic.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    finger_nxt_s = finger_r;
    cmd_nxt_s    = cmd_r;
    target_nxt_s = target_r;
    done_nxt_s   = 1'b0;
    err_nxt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (sign_valid) begin
          if (lut_s[5]) begin
            target_nxt_s = lut_s[4:0];
            cmd_nxt_s[4] = lut_s[4];
            finger_nxt_s = 3'd1;
            cnt_nxt_s    = 16'd0;
            state_nxt_s  = STEP;
          end else begin
            err_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      STEP: begin
        if (abort) begin
          cmd_nxt_s    = 5'b00000;
          cnt_nxt_s    = 16'd0;
          finger_nxt_s = 3'd0;
          state_nxt_s  = IDLE;
        end else if (cnt_r == STEP_LAST) begin
          cnt_nxt_s = 16'd0;
          // finger_r reaching 5 means every finger has been placed.
          if (finger_r == 3'd5) begin
            finger_nxt_s = 3'd0;
            state_nxt_s  = HOLD;
          end else begin
            cmd_nxt_s[finger_idx_s] = target_r[finger_idx_s];
            finger_nxt_s            = finger_r + 3'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      HOLD: begin
        if (abort) begin
          cmd_nxt_s   = 5'b00000;
          cnt_nxt_s   = 16'd0;
          state_nxt_s = IDLE;
        end else if (cnt_r == HOLD_LAST) begin
          cnt_nxt_s   = 16'd0;
          done_nxt_s  = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      default: begin
        cmd_nxt_s   = 5'b00000;
        cnt_nxt_s   = 16'd0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= 16'd0;
      finger_r <= 3'd0;
      cmd_r    <= 5'b00000;
      target_r <= 5'b00000;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      finger_r <= finger_nxt_s;
      cmd_r    <= cmd_nxt_s;
      target_r <= target_nxt_s;
      done_r   <= done_nxt_s;
      err_r    <= err_nxt_s;
    end
  end

  assign thumb_cmd  = cmd_r[4];
  assign index_cmd  = cmd_r[3];
  assign middle_cmd = cmd_r[2];
  assign ring_cmd   = cmd_r[1];
  assign pinky_cmd  = cmd_r[0];
  assign busy       = (state_r != IDLE);
  assign sign_ready = (state_r == IDLE);
  assign done       = done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_sign_actuation.sv
// Directed self-checking bench for sign_actuation with STEP_CYCLES=2, HOLD_CYCLES=3.
module tb_sign_actuation;

  logic       clk;
  logic       rst;
  logic [3:0] sign_in;
  logic       sign_valid;
  logic       sign_ready;
  logic       abort;
  logic       thumb_cmd, index_cmd, middle_cmd, ring_cmd, pinky_cmd;
  logic       busy, done, err;
  logic [4:0] cmd;
  int         n_cmp;
  int         n_bad;

  sign_actuation #(.STEP_CYCLES(2), .HOLD_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .sign_in(sign_in), .sign_valid(sign_valid),
    .sign_ready(sign_ready), .abort(abort),
    .thumb_cmd(thumb_cmd), .index_cmd(index_cmd), .middle_cmd(middle_cmd),
    .ring_cmd(ring_cmd), .pinky_cmd(pinky_cmd),
    .busy(busy), .done(done), .err(err)
  );

  assign cmd = {thumb_cmd, index_cmd, middle_cmd, ring_cmd, pinky_cmd};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge, then settle to the falling edge for sampling and driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (cmd !== 5'b00000) begin n_bad++; $display("FAIL reset_cmd got %b want 00000", cmd); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    rst = 1'b0;
    tick();
    n_cmp++; if (sign_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", sign_ready); end
  endtask

  task automatic test_code5();
    logic [4:0] exp;
    sign_in = 4'd5; sign_valid = 1'b1;
    tick();
    sign_valid = 1'b0;
    n_cmp++; if (cmd !== 5'b10000) begin n_bad++; $display("FAIL c5_accept_cmd got %b want 10000", cmd); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL c5_accept_busy got %b want 1", busy); end
    n_cmp++; if (sign_ready !== 1'b0) begin n_bad++; $display("FAIL c5_accept_ready got %b want 0", sign_ready); end
    for (int e = 1; e <= 13; e++) begin
      tick();
      exp = 5'b00000;
      for (int k = 0; k < 5; k++) begin
        if (2 * k <= e) exp[4-k] = 1'b1;
      end
      n_cmp++; if (cmd !== exp) begin n_bad++; $display("FAIL c5_cmd at A+%0d got %b want %b", e, cmd, exp); end
      n_cmp++; if (done !== (e == 13)) begin n_bad++; $display("FAIL c5_done at A+%0d got %b want %b", e, done, (e == 13)); end
      n_cmp++; if (busy !== (e != 13)) begin n_bad++; $display("FAIL c5_busy at A+%0d got %b want %b", e, busy, (e != 13)); end
    end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL c5_done_after got %b want 0", done); end
    n_cmp++; if (cmd !== 5'b11111) begin n_bad++; $display("FAIL c5_retain got %b want 11111", cmd); end
  endtask

  task automatic test_code9();
    sign_in = 4'd9; sign_valid = 1'b1;
    tick();
    sign_valid = 1'b0;
    n_cmp++; if (cmd !== 5'b01111) begin n_bad++; $display("FAIL c9_A got %b want 01111", cmd); end
    repeat (4) tick();
    n_cmp++; if (cmd !== 5'b01011) begin n_bad++; $display("FAIL c9_A4 got %b want 01011", cmd); end
    repeat (2) tick();
    n_cmp++; if (cmd !== 5'b01001) begin n_bad++; $display("FAIL c9_A6 got %b want 01001", cmd); end
    repeat (6) tick();
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL c9_A12 busy/done got %b%b want 10", busy, done); end
    tick();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL c9_done got %b want 1", done); end
    n_cmp++; if (cmd !== 5'b01001) begin n_bad++; $display("FAIL c9_final got %b want 01001", cmd); end
  endtask

  task automatic test_unsupported();
    sign_in = 4'd12; sign_valid = 1'b1;
    tick();
    sign_valid = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL bad_err got %b want 1", err); end
    n_cmp++; if (sign_ready !== 1'b1) begin n_bad++; $display("FAIL bad_ready got %b want 1", sign_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bad_busy got %b want 0", busy); end
    n_cmp++; if (cmd !== 5'b01001) begin n_bad++; $display("FAIL bad_cmd got %b want 01001", cmd); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL bad_done got %b want 0", done); end
    tick();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL bad_err_pulse got %b want 0", err); end
  endtask

  task automatic test_abort();
    sign_in = 4'd4; sign_valid = 1'b1;
    tick();
    sign_valid = 1'b0;
    n_cmp++; if (cmd !== 5'b01001) begin n_bad++; $display("FAIL ab_A got %b want 01001", cmd); end
    repeat (4) tick();
    n_cmp++; if (cmd !== 5'b01101) begin n_bad++; $display("FAIL ab_A4 got %b want 01101", cmd); end
    abort = 1'b1;
    tick();
    n_cmp++; if (cmd !== 5'b00000) begin n_bad++; $display("FAIL ab_cmd got %b want 00000", cmd); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ab_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL ab_done got %b want 0", done); end
    // abort stays high while idle: the new sign must still be accepted.
    sign_in = 4'd3; sign_valid = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ab_next_busy got %b want 1", busy); end
    n_cmp++; if (cmd !== 5'b00000) begin n_bad++; $display("FAIL ab_next_cmd got %b want 00000", cmd); end
  endtask

  task automatic test_back_to_back();
    for (int e = 1; e <= 12; e++) begin
      sign_in = 4'(e);
      tick();
      n_cmp++; if (busy !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_err at A+%0d got %b%b want 10", e, busy, err); end
    end
    n_cmp++; if (cmd !== 5'b01110) begin n_bad++; $display("FAIL b2b_A12 got %b want 01110", cmd); end
    sign_in = 4'd8;
    tick();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done got %b want 1", done); end
    n_cmp++; if (sign_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got %b want 1", sign_ready); end
    n_cmp++; if (cmd !== 5'b01110) begin n_bad++; $display("FAIL b2b_pattern got %b want 01110", cmd); end
    tick();
    sign_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_next_busy got %b want 1", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_next_done got %b want 0", done); end
    n_cmp++; if (cmd !== 5'b11110) begin n_bad++; $display("FAIL b2b_next_cmd got %b want 11110", cmd); end
  endtask

  task automatic test_reset_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0 || cmd !== 5'b00000) begin n_bad++; $display("FAIL ra_pre busy/cmd got %b/%b want 0/00000", busy, cmd); end
    sign_in = 4'd7; sign_valid = 1'b1;
    tick();
    sign_valid = 1'b0;
    n_cmp++; if (cmd !== 5'b10000) begin n_bad++; $display("FAIL ra_A got %b want 10000", cmd); end
    repeat (2) tick();
    n_cmp++; if (cmd !== 5'b11000) begin n_bad++; $display("FAIL ra_A2 got %b want 11000", cmd); end
    rst = 1'b1; abort = 1'b1; sign_valid = 1'b1; sign_in = 4'd5;
    tick();
    rst = 1'b0; abort = 1'b0; sign_valid = 1'b0;
    n_cmp++; if (cmd !== 5'b00000) begin n_bad++; $display("FAIL ra_cmd got %b want 00000", cmd); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL ra_flags busy/done/err got %b%b%b want 000", busy, done, err); end
    n_cmp++; if (sign_ready !== 1'b1) begin n_bad++; $display("FAIL ra_ready got %b want 1", sign_ready); end
    tick();
    n_cmp++; if (sign_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL ra_released ready/busy got %b%b want 10", sign_ready, busy); end
    n_cmp++; if (cmd !== 5'b00000) begin n_bad++; $display("FAIL ra_released_cmd got %b want 00000", cmd); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; sign_in = 4'd0; sign_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    test_reset();
    test_code5();
    test_code9();
    test_unsupported();
    test_abort();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
